// File: rtl/cpu_pkg.sv
// Shared CPU-side bus types: IBUS byte-enable constant and the line-fill FSM states.
package CPU_PKG;

  localparam logic [3:0] IBUS_BA_LONG = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT
  } LineFillState_t;

endpackage

// File: rtl/ibus_line_fill.sv
// Cache line-fill engine: locked burst of longword reads over the IBUS REQ/BUSY handshake.
// Build option LINE_FILL_CWF_EN selects critical-word-first ordering (default: ascending from index 0).
//
// state | meaning
// IDLE  | no fill in progress, bus released
// ARM   | beat requested, waiting for BUSY=1
// WAIT  | BSC busy with the beat, waiting for BUSY=0
module ibus_line_fill
  import CPU_PKG::*;
#(
  parameter int BEATS_LOG2 = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CE_R,
  input  logic                  RES_N,
  input  logic                  FILL_REQ,
  input  logic [31:0]           FILL_A,
  output logic                  FILL_ACK,
  output logic                  LINE_WE,
  output logic [BEATS_LOG2-1:0] LINE_IDX,
  output logic [31:0]           LINE_DATA,
  output logic                  CRIT_VALID,
  output logic                  FILL_DONE,
  output logic [31:0]           IBUS_A,
  output logic [3:0]            IBUS_BA,
  output logic                  IBUS_WE,
  output logic                  IBUS_REQ,
  output logic                  IBUS_LOCK,
  input  logic                  IBUS_BUSY,
  input  logic [31:0]           IBUS_DI
);

  localparam int LA_W = 30 - BEATS_LOG2;
  localparam logic [BEATS_LOG2-1:0] LAST_BEAT = '1;

  LineFillState_t        state;
  logic [LA_W-1:0]       la;
  logic [BEATS_LOG2-1:0] cw;
  logic [BEATS_LOG2-1:0] idx;
  logic [BEATS_LOG2-1:0] cnt;
  logic                  req;

  // Byte offset within the missed longword is irrelevant to a line fill.
  logic unused_fill_a_lsb;
  assign unused_fill_a_lsb = ^FILL_A[1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      la         <= '0;
      cw         <= '0;
      idx        <= '0;
      cnt        <= '0;
      req        <= 1'b0;
      FILL_ACK   <= 1'b0;
      LINE_WE    <= 1'b0;
      LINE_IDX   <= '0;
      LINE_DATA  <= '0;
      CRIT_VALID <= 1'b0;
      FILL_DONE  <= 1'b0;
    end else begin
      // Strobes last exactly one CLK regardless of the CE_R duty.
      FILL_ACK   <= 1'b0;
      LINE_WE    <= 1'b0;
      CRIT_VALID <= 1'b0;
      FILL_DONE  <= 1'b0;
      if (CE_R) begin
        if (!RES_N) begin
          state <= IDLE;
          req   <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (FILL_REQ) begin
                la       <= FILL_A[31:2+BEATS_LOG2];
                cw       <= FILL_A[1+BEATS_LOG2:2];
`ifdef LINE_FILL_CWF_EN
                idx      <= FILL_A[1+BEATS_LOG2:2];
`else
                idx      <= '0;
`endif
                cnt      <= '0;
                req      <= 1'b1;
                FILL_ACK <= 1'b1;
                state    <= ARM;
              end
            end
            ARM: begin
              if (IBUS_BUSY) state <= WAIT;
            end
            WAIT: begin
              if (!IBUS_BUSY) begin
                LINE_DATA  <= IBUS_DI;
                LINE_IDX   <= idx;
                LINE_WE    <= 1'b1;
                CRIT_VALID <= (idx == cw);
                if (cnt == LAST_BEAT) begin
                  req       <= 1'b0;
                  FILL_DONE <= 1'b1;
                  state     <= IDLE;
                end else begin
                  idx   <= idx + 1'b1;
                  cnt   <= cnt + 1'b1;
                  state <= ARM;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Lock tracks request so the arbiter never sees a gap between beats.
  assign IBUS_REQ  = req;
  assign IBUS_LOCK = req;
  assign IBUS_A    = req ? {la, idx, 2'b00} : 32'h0;
  assign IBUS_BA   = IBUS_BA_LONG;
  assign IBUS_WE   = 1'b0;

endmodule

// File: tb/tb_ibus_line_fill.sv
// Scoreboard bench for ibus_line_fill: BSC model with memory image, reference beat queue, monitor.
module tb_ibus_line_fill;

  localparam int B = 2;
  localparam int BEATS = 1 << B;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CE_R = 1'b1;
  logic          RES_N = 1'b1;
  logic          FILL_REQ = 1'b0;
  logic [31:0]   FILL_A = '0;
  logic          FILL_ACK, LINE_WE, CRIT_VALID, FILL_DONE;
  logic [B-1:0]  LINE_IDX;
  logic [31:0]   LINE_DATA, IBUS_A;
  logic [3:0]    IBUS_BA;
  logic          IBUS_WE, IBUS_REQ, IBUS_LOCK;
  logic          IBUS_BUSY = 1'b0;
  logic [31:0]   IBUS_DI = '0;

  ibus_line_fill #(.BEATS_LOG2(B)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N),
    .FILL_REQ(FILL_REQ), .FILL_A(FILL_A), .FILL_ACK(FILL_ACK),
    .LINE_WE(LINE_WE), .LINE_IDX(LINE_IDX), .LINE_DATA(LINE_DATA),
    .CRIT_VALID(CRIT_VALID), .FILL_DONE(FILL_DONE),
    .IBUS_A(IBUS_A), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE),
    .IBUS_REQ(IBUS_REQ), .IBUS_LOCK(IBUS_LOCK),
    .IBUS_BUSY(IBUS_BUSY), .IBUS_DI(IBUS_DI)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [B-1:0] idx;
    logic [31:0]  data;
    logic         crit;
    logic         done;
  } beat_t;

  beat_t sb_q[$];
  int checks = 0;
  int failures = 0;

  bit ce_random = 1'b0;
  int cfg_ws_min = 0, cfg_ws_max = 0;
  int cfg_dly_max = 0;
  int cfg_first_dly = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_1234) * 32'h9E37_79B1) + 32'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: a line is read as consecutive longwords from the start index, wrapping.
  task automatic push_fill(input logic [31:0] addr);
    int cw, start, i;
    logic [31:0] base;
    cw = int'(addr[B+1:2]);
    base = {addr[31:B+2], {(B+2){1'b0}}};
`ifdef LINE_FILL_CWF_EN
    start = cw;
`else
    start = 0;
`endif
    for (int k = 0; k < BEATS; k++) begin
      beat_t e;
      i = (start + k) % BEATS;
      e.idx  = B'(i);
      e.data = mem_word(base + 32'(i * 4));
      e.crit = (i == cw);
      e.done = (k == BEATS - 1);
      sb_q.push_back(e);
    end
  endtask

  // BSC model and CE_R generator; BSC only acts on edges the DUT actually sampled.
  int bsc_rem = 0;
  int bsc_dly = 0;
  initial begin
    forever begin
      @(negedge CLK);
      if (CE_R && RST_N) begin
        if (IBUS_BUSY) begin
          if (bsc_rem == 0) begin
            IBUS_BUSY = 1'b0;
            IBUS_DI   = mem_word(IBUS_A);
            bsc_dly   = $urandom_range(cfg_dly_max, 0);
          end else bsc_rem--;
        end else if (IBUS_REQ) begin
          if (bsc_dly == 0) begin
            IBUS_BUSY = 1'b1;
            IBUS_DI   = $urandom;
            bsc_rem   = $urandom_range(cfg_ws_max, cfg_ws_min);
          end else bsc_dly--;
        end else begin
          bsc_dly = (cfg_first_dly >= 0) ? cfg_first_dly : $urandom_range(cfg_dly_max, 0);
        end
      end
      CE_R = ce_random ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Monitor: bus invariants every cycle, beats popped against the reference queue.
  initial begin
    beat_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (RST_N) begin
        chk("lock_eq_req", 32'(IBUS_LOCK), 32'(IBUS_REQ));
        chk("bus_we_ba", {27'd0, IBUS_WE, IBUS_BA}, 32'h0000_000F);
        if (LINE_WE) begin
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat actual=idx%0d required=none t=%0t", LINE_IDX, $time);
          end else begin
            e = sb_q.pop_front();
            chk("line_idx", 32'(LINE_IDX), 32'(e.idx));
            chk("line_data", LINE_DATA, e.data);
            chk("crit_valid", 32'(CRIT_VALID), 32'(e.crit));
            chk("fill_done", 32'(FILL_DONE), 32'(e.done));
          end
        end else begin
          chk("stray_strobe", {30'd0, CRIT_VALID, FILL_DONE}, 32'h0);
        end
      end
    end
  end

  task automatic issue_fill(input logic [31:0] addr);
    int n;
    push_fill(addr);
    @(negedge CLK);
    FILL_A = addr;
    FILL_REQ = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!FILL_ACK && n < 400);
    if (!FILL_ACK) begin
      checks++; failures++;
      $display("FAIL ack_timeout actual=0 required=1 addr=%h", addr);
    end
    FILL_REQ = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!FILL_DONE && n < 2000);
    if (!FILL_DONE) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_line_we", 32'(LINE_WE), 0);
    chk("rst_line_idx", 32'(LINE_IDX), 0);
    chk("rst_line_data", LINE_DATA, 0);
    chk("rst_ibus_a", IBUS_A, 0);
    chk("rst_req_lock", {30'd0, IBUS_REQ, IBUS_LOCK}, 0);
    chk("rst_strobes", {29'd0, FILL_ACK, FILL_DONE, CRIT_VALID}, 0);
    chk("rst_ba_we", {27'd0, IBUS_WE, IBUS_BA}, 32'h0000_000F);
    @(negedge CLK);
    RST_N = 1'b1;
    idle_cycles(3);

    // Basic fill, one wait state.
    cfg_ws_min = 1; cfg_ws_max = 1; cfg_dly_max = 0; cfg_first_dly = 0;
    issue_fill(32'h0600_0048);
    wait_done();
    idle_cycles(3);

    // BUSY held low for 5 CE_R after the request.
    cfg_first_dly = 5;
    issue_fill(32'h0600_0048);
    wait_done();
    cfg_first_dly = 0;
    idle_cycles(3);

    // Soft reset while waiting on beat 1.
    cfg_ws_min = 3; cfg_ws_max = 3;
    issue_fill(32'h0000_1234);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!LINE_WE && n < 200);
    chk("abort_first_beat", 32'(LINE_WE), 1);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!IBUS_BUSY && n < 200);
    chk("abort_busy_seen", 32'(IBUS_BUSY), 1);
    @(negedge CLK);
    RES_N = 1'b0;
    sb_q.delete();
    @(posedge CLK);
    #1;
    chk("abort_req_lock", {30'd0, IBUS_REQ, IBUS_LOCK}, 0);
    @(negedge CLK);
    RES_N = 1'b1;
    idle_cycles(20);
    cfg_ws_min = 0; cfg_ws_max = 1;
    issue_fill(32'h0000_1234);
    wait_done();
    idle_cycles(3);

    // Back-to-back misses with a pending second request.
    cfg_ws_min = 0; cfg_ws_max = 0;
    issue_fill(32'h0000_0010);
    push_fill(32'h0000_0020);
    FILL_A = 32'h0000_0020;
    FILL_REQ = 1'b1;
    wait_done();
    chk("b2b_lock_gap", 32'(IBUS_LOCK), 0);
    @(posedge CLK);
    #1;
    chk("b2b_ack_next_ce", 32'(FILL_ACK), 1);
    chk("b2b_lock_back", 32'(IBUS_LOCK), 1);
    @(negedge CLK);
    FILL_REQ = 1'b0;
    wait_done();
    idle_cycles(3);

    // Randomized fills with gated CE_R and variable BSC latency.
    ce_random = 1'b1;
    cfg_ws_min = 0; cfg_ws_max = 3; cfg_dly_max = 2; cfg_first_dly = -1;
    for (int t = 0; t < 25; t++) begin
      issue_fill($urandom);
      wait_done();
      idle_cycles($urandom_range(3, 0));
    end
    ce_random = 1'b0;

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge CLK); n++; end
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
